// File: rtl/plic_irq_conditioner.sv
// plic_irq_conditioner: per-source synchronizer, debounce filter, level/edge
// output conditioning and saturating event counters ahead of the PLIC gateway.
module plic_irq_conditioner #(
   parameter int unsigned N_SOURCE    = 30,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_W      = 3,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [N_SOURCE-1:0]         irq_raw_i,
   input  logic [N_SOURCE-1:0]         inv_i,
   input  logic [N_SOURCE-1:0]         le_cfg_i,
   input  logic [N_SOURCE-1:0]         filt_en_i,
   input  logic [N_SOURCE-1:0]         mask_i,
   input  logic [N_SOURCE-1:0]         cnt_clr_i,
   output logic [N_SOURCE-1:0]         irq_src_o,
   output logic [N_SOURCE-1:0]         le_o,
   output logic [N_SOURCE*CNT_W-1:0]   evt_cnt_o
);

   // Counter value on which the next differing cycle toggles the filter state.
   localparam int unsigned FILT_LAST = (2 ** FILT_W) - 2;

   logic [SYNC_STAGES-1:0][N_SOURCE-1:0] sync_q, sync_d;
   logic [N_SOURCE-1:0]                  f_q, f_d;
   logic [N_SOURCE-1:0][FILT_W-1:0]      c_q, c_d;
   logic [N_SOURCE-1:0]                  fdly_q;
   logic [N_SOURCE-1:0]                  irq_q, irq_d;
   logic [N_SOURCE-1:0]                  le_q;
   logic [N_SOURCE-1:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic [N_SOURCE-1:0]                  s_c;
   logic [N_SOURCE-1:0]                  rise_c;

   // Synchronizer shift chain; polarity applied after the last stage.
   always_comb begin
      sync_d[0] = irq_raw_i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
      s_c    = sync_q[SYNC_STAGES-1] ^ inv_i;
      rise_c = f_q & ~fdly_q;
   end

   // Debounce filter: toggle f only after a full run of differing cycles.
   always_comb begin
      f_d = f_q;
      c_d = '0;
      for (int unsigned i = 0; i < N_SOURCE; i++) begin
         if (!filt_en_i[i]) begin
            f_d[i] = s_c[i];
         end else if (s_c[i] != f_q[i]) begin
            if (c_q[i] == FILT_W'(FILT_LAST)) begin
               f_d[i] = s_c[i];
            end else begin
               c_d[i] = c_q[i] + FILT_W'(1);
            end
         end
      end
   end

   // Output conditioning: level passes f, edge passes a one-cycle rise pulse.
   always_comb begin
      irq_d = '0;
      for (int unsigned i = 0; i < N_SOURCE; i++) begin
         if (le_cfg_i[i]) begin
            irq_d[i] = rise_c[i] & ~mask_i[i];
         end else begin
            irq_d[i] = f_q[i] & ~mask_i[i];
         end
      end
   end

   // Saturating event counters; clear wins over a same-cycle increment.
   always_comb begin
      cnt_d = cnt_q;
      for (int unsigned i = 0; i < N_SOURCE; i++) begin
         if (cnt_clr_i[i]) begin
            cnt_d[i] = '0;
         end else if (rise_c[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         f_q    <= '0;
         c_q    <= '0;
         fdly_q <= '0;
         irq_q  <= '0;
         le_q   <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         f_q    <= f_d;
         c_q    <= c_d;
         fdly_q <= f_q;
         irq_q  <= irq_d;
         le_q   <= le_cfg_i;
         cnt_q  <= cnt_d;
      end
   end

   assign irq_src_o = irq_q;
   assign le_o      = le_q;
   assign evt_cnt_o = cnt_q;

endmodule
